// File: rtl/gbt_rx_phalgnr_dps_pkg.sv
// Shared types and constants for the RX frame-clock phase aligner DPS sequencer.
package gbt_rx_phalgnr_dps_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } dps_state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_TO_LO  = 2'd1;
  localparam logic [1:0] ERR_TO_HI  = 2'd2;
  localparam logic [1:0] ERR_UNLOCK = 2'd3;

  localparam int unsigned STEPS_PER_PER_DEF = 144;
  localparam logic [4:0]  CNTSEL_C0         = 5'd0;

  // One DPS step around a position ring of the given modulus (wraps, never saturates)
  function automatic int unsigned pos_step(input int unsigned pos, input logic up,
                                           input int unsigned modulus);
    if (up) begin
      return (pos == modulus - 1) ? 0 : pos + 1;
    end
    return (pos == 0) ? modulus - 1 : pos - 1;
  endfunction

endpackage

// File: rtl/gbt_rx_phalgnr_sync2.sv
// Two-flop synchroniser for asynchronous PLL status inputs, resets to 0.
module gbt_rx_phalgnr_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Cyclone V PLL dynamic-phase-shift sequencer for the 40 MHz RX frame clock.
// Optional macro GBT_RX_PHALGNR_DPS_STATS_EN adds stat_steps/stat_errs counters.
module gbt_rx_frameclk_phalgnr_dps_ctrl
  import gbt_rx_phalgnr_dps_pkg::*;
#(
  parameter logic [4:0]  CNTSEL_C      = CNTSEL_C0,
  parameter int unsigned PHASE_EN_CYC  = 2,
  parameter int unsigned DONE_TIMEOUT  = 255,
  parameter int unsigned STEPS_PER_PER = STEPS_PER_PER_DEF,
  parameter int unsigned POS_W         = 8
) (
  input  logic             scanclk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [POS_W-1:0] req_steps,
  input  logic             req_up,
  input  logic             pll_locked,
  output logic             pll_phase_en,
  output logic             pll_updn,
  output logic [4:0]       pll_cntsel,
  input  logic             pll_phase_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [POS_W-1:0] phase_pos
`ifdef GBT_RX_PHALGNR_DPS_STATS_EN
  ,
  output logic [15:0]      stat_steps,
  output logic [7:0]       stat_errs
`endif
);

  localparam int unsigned PE_W = (PHASE_EN_CYC > 1) ? $clog2(PHASE_EN_CYC) : 1;
  localparam int unsigned TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  logic             w_lock_s;
  logic             w_done_s;
  logic             w_xfer;
  logic             w_unlock;
  logic             r_lock_d;
  dps_state_e       r_state;
  logic [POS_W-1:0] r_rem;
  logic [POS_W-1:0] r_pos;
  logic             r_dir;
  logic [PE_W-1:0]  r_pcnt;
  logic [TO_W-1:0]  r_tcnt;
  logic             r_phase_en;
  logic             r_updn;
  logic [4:0]       r_cntsel;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;

  gbt_rx_phalgnr_sync2 u_sync_lock (
    .clk   (scanclk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_lock_s)
  );

  gbt_rx_phalgnr_sync2 u_sync_done (
    .clk   (scanclk),
    .rst_n (rst_n),
    .i_d   (pll_phase_done),
    .o_q   (w_done_s)
  );

  assign req_ready = (r_state == IDLE) & w_lock_s;
  assign w_xfer    = req_valid & req_ready;
  // Lock loss aborts any in-flight work; ERR already heads back to IDLE
  assign w_unlock  = ~w_lock_s & (r_state != IDLE) & (r_state != ERR);

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lock_d   <= 1'b0;
      r_rem      <= '0;
      r_pos      <= '0;
      r_dir      <= 1'b0;
      r_pcnt     <= '0;
      r_tcnt     <= '0;
      r_phase_en <= 1'b0;
      r_updn     <= 1'b0;
      r_cntsel   <= CNTSEL_C;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_done   <= 1'b0;
      r_lock_d <= w_lock_s;
      r_cntsel <= CNTSEL_C;
      if (w_unlock) begin
        r_state    <= ERR;
        r_phase_en <= 1'b0;
        r_busy     <= 1'b0;
        r_err      <= 1'b1;
        r_err_code <= ERR_UNLOCK;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_xfer) begin
              r_rem      <= req_steps;
              r_dir      <= req_up;
              r_err      <= 1'b0;
              r_err_code <= ERR_NONE;
              if (req_steps == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= SETUP;
                r_busy  <= 1'b1;
                r_updn  <= req_up;
              end
            end
          end
          SETUP: begin
            r_state    <= PULSE;
            r_phase_en <= 1'b1;
            r_pcnt     <= '0;
          end
          PULSE: begin
            if (r_pcnt == PE_W'(PHASE_EN_CYC - 1)) begin
              r_state    <= WAIT_LO;
              r_phase_en <= 1'b0;
              r_tcnt     <= '0;
            end else begin
              r_pcnt <= r_pcnt + PE_W'(1);
            end
          end
          WAIT_LO: begin
            if (!w_done_s) begin
              r_state <= WAIT_HI;
              r_tcnt  <= '0;
            end else if (r_tcnt == TO_W'(DONE_TIMEOUT - 1)) begin
              r_state    <= ERR;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
              r_err_code <= ERR_TO_LO;
            end else begin
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end
          WAIT_HI: begin
            if (w_done_s) begin
              r_state <= NEXT;
            end else if (r_tcnt == TO_W'(DONE_TIMEOUT - 1)) begin
              r_state    <= ERR;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
              r_err_code <= ERR_TO_HI;
            end else begin
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end
          NEXT: begin
            r_rem <= r_rem - POS_W'(1);
            r_pos <= POS_W'(pos_step(32'(r_pos), r_dir, STEPS_PER_PER));
            if (r_rem != POS_W'(1)) begin
              r_state <= SETUP;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          DONE:    r_state <= IDLE;
          ERR:     r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
      // Relock restores the programmed phase, so the tracked position follows
      if (r_lock_d && !w_lock_s) begin
        r_pos <= '0;
      end
    end
  end

  assign pll_phase_en = r_phase_en;
  assign pll_updn     = r_updn;
  assign pll_cntsel   = r_cntsel;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign err_code     = r_err_code;
  assign phase_pos    = r_pos;

`ifdef GBT_RX_PHALGNR_DPS_STATS_EN
  logic [15:0] r_stat_steps;
  logic [7:0]  r_stat_errs;

  // Saturating statistics, cleared only by rst_n
  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_steps <= '0;
      r_stat_errs  <= '0;
    end else begin
      if (r_state == NEXT && !w_unlock && r_stat_steps != '1) begin
        r_stat_steps <= r_stat_steps + 16'd1;
      end
      if (r_state == ERR && r_stat_errs != '1) begin
        r_stat_errs <= r_stat_errs + 8'd1;
      end
    end
  end

  assign stat_steps = r_stat_steps;
  assign stat_errs  = r_stat_errs;
`endif

endmodule

// File: tb/tb_gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Self-checking bench: table vectors, randomized requests vs a modular-position model,
// plus timeout, lock-loss and mid-pulse reset sequences.
module tb_gbt_rx_frameclk_phalgnr_dps_ctrl;

  localparam int STEPS = 144;
  localparam int TO    = 255;

  logic       scanclk        = 1'b0;
  logic       rst_n          = 1'b0;
  logic       req_valid      = 1'b0;
  logic [7:0] req_steps      = 8'd0;
  logic       req_up         = 1'b0;
  logic       pll_locked     = 1'b0;
  logic       pll_phase_done = 1'b1;
  logic       req_ready, pll_phase_en, pll_updn, busy, done, err;
  logic [4:0] pll_cntsel;
  logic [1:0] err_code;
  logic [7:0] phase_pos;
`ifdef GBT_RX_PHALGNR_DPS_STATS_EN
  logic [15:0] stat_steps;
  logic [7:0]  stat_errs;
`endif

  gbt_rx_frameclk_phalgnr_dps_ctrl dut (
    .scanclk        (scanclk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_steps      (req_steps),
    .req_up         (req_up),
    .pll_locked     (pll_locked),
    .pll_phase_en   (pll_phase_en),
    .pll_updn       (pll_updn),
    .pll_cntsel     (pll_cntsel),
    .pll_phase_done (pll_phase_done),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code),
    .phase_pos      (phase_pos)
`ifdef GBT_RX_PHALGNR_DPS_STATS_EN
    ,
    .stat_steps     (stat_steps),
    .stat_errs      (stat_errs)
`endif
  );

  always #5 scanclk = ~scanclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Output monitor on the falling edge
  int   cyc = 0, pulses = 0, done_cnt = 0;
  int   bad_width = 0, bad_updn = 0, bad_cntsel = 0, width = 0;
  logic cur_up = 1'b0, pe_prev = 1'b0;

  always @(negedge scanclk) begin
    cyc++;
    if (!rst_n) begin
      pe_prev = 1'b0;
      width   = 0;
    end else begin
      if (pll_phase_en === 1'b1) begin
        if (!pe_prev) begin
          pulses++;
          width = 0;
        end
        width++;
        if (pll_updn !== cur_up) bad_updn++;
      end else if (pe_prev && width != 2) begin
        bad_width++;
      end
      pe_prev = (pll_phase_en === 1'b1);
      if (done === 1'b1) done_cnt++;
      if (pll_cntsel !== 5'd0) bad_cntsel++;
    end
  end

  // PLL phase_done model: low 2 cycles after phase_en rises, high again hi_delay later
  int   hi_delay = 3, lo_at = -1, hi_at = -1, mcyc = 0;
  bit   never_lower = 1'b0;
  logic mpe_prev = 1'b0;

  always @(negedge scanclk) begin
    mcyc++;
    if (pll_phase_en === 1'b1 && !mpe_prev && !never_lower) begin
      lo_at = mcyc + 2;
      hi_at = mcyc + 2 + hi_delay;
    end
    mpe_prev = (pll_phase_en === 1'b1);
    if (mcyc == lo_at) pll_phase_done = 1'b0;
    if (mcyc == hi_at) pll_phase_done = 1'b1;
  end

  // Reference: absolute position on a 144-step ring
  int ref_pos = 0, exp_steps = 0, exp_errs = 0;

  function automatic int wrap(input int p);
    return ((p % STEPS) + STEPS) % STEPS;
  endfunction

  task automatic tick();
    @(negedge scanclk);
    #1;
  endtask

  task automatic do_req(input int n, input bit up, output int p0, output int d0);
    int k;
    k = 0;
    tick();
    while (req_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("ready_wait", req_ready, 1);
    cur_up    = up;
    p0        = pulses;
    d0        = done_cnt;
    req_valid = 1'b1;
    req_steps = 8'(n);
    req_up    = up;
    @(posedge scanclk);
    #1 req_valid = 1'b0;
    chk("err_clr", err, 0);
    if (n == 0) chk("zero_done_next", done, 1);
  endtask

  task automatic finish_req(input string name, input int n, input int exp_pos,
                            input int p0, input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && err !== 1'b1 && k < n * 60 + 60) begin
      tick();
      k++;
    end
    chk($sformatf("%s_in_time", name), 32'(k < n * 60 + 60), 1);
    tick();
    tick();
    chk($sformatf("%s_pos", name), phase_pos, exp_pos);
    chk($sformatf("%s_pulses", name), pulses - p0, n);
    chk($sformatf("%s_done_pulses", name), done_cnt - d0, 1);
    chk($sformatf("%s_err", name), err, 0);
    chk($sformatf("%s_busy", name), busy, 0);
    chk($sformatf("%s_pe_width_bad", name), bad_width, 0);
    chk($sformatf("%s_updn_bad", name), bad_updn, 0);
    chk($sformatf("%s_cntsel_bad", name), bad_cntsel, 0);
    ref_pos   = exp_pos;
    exp_steps = exp_steps + n;
  endtask

  task automatic wait_err(input int budget, output int lat);
    int k;
    k = 0;
    while (err !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    lat = k;
  endtask

  typedef struct {
    int steps;
    bit up;
    int exp_pos;
  } vec_t;

  vec_t vt[7];

  initial begin
    int p0, d0, lat, k, n, rdy_hi, p_rst;
    bit up;
    vt[0] = '{3, 1'b1, 3};
    vt[1] = '{3, 1'b0, 0};
    vt[2] = '{1, 1'b0, 143};
    vt[3] = '{144, 1'b1, 143};
    vt[4] = '{0, 1'b1, 143};
    vt[5] = '{5, 1'b0, 138};
    vt[6] = '{10, 1'b1, 4};

    repeat (3) tick();
    chk("rst_phase_en", pll_phase_en, 0);
    chk("rst_updn", pll_updn, 0);
    chk("rst_cntsel", pll_cntsel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_pos", phase_pos, 0);
    chk("rst_ready", req_ready, 0);
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("ready_after_lock", req_ready, 1);

    for (int i = 0; i < 7; i++) begin
      do_req(vt[i].steps, vt[i].up, p0, d0);
      finish_req($sformatf("vec%0d", i), vt[i].steps, vt[i].exp_pos, p0, d0);
    end

    for (int i = 0; i < 8; i++) begin
      n  = $urandom_range(0, 12);
      up = 1'($urandom_range(0, 1));
      do_req(n, up, p0, d0);
      finish_req($sformatf("rnd%0d", i), n, wrap(ref_pos + (up ? n : -n)), p0, d0);
    end

    // phase_done never lowered: done-low timeout
    never_lower = 1'b1;
    do_req(1, 1'b1, p0, d0);
    k = cyc;
    wait_err(400, lat);
    lat = cyc - k;
    chk("tolo_err", err, 1);
    chk("tolo_code", err_code, 1);
    chk("tolo_busy", busy, 0);
    chk("tolo_phase_en", pll_phase_en, 0);
    chk("tolo_pos", phase_pos, ref_pos);
    chk("tolo_latency_window", 32'(lat >= TO && lat <= TO + 8), 1);
    chk("tolo_no_done", done_cnt - d0, 0);
    exp_errs++;
    never_lower = 1'b0;
    do_req(1, 1'b1, p0, d0);
    finish_req("recover", 1, wrap(ref_pos + 1), p0, d0);

    // phase_done held low too long: done-high timeout
    hi_delay = 300;
    do_req(1, 1'b0, p0, d0);
    wait_err(400, lat);
    chk("tohi_err", err, 1);
    chk("tohi_code", err_code, 2);
    chk("tohi_busy", busy, 0);
    chk("tohi_pos", phase_pos, ref_pos);
    exp_errs++;
    k = 0;
    while (pll_phase_done !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    chk("tohi_done_restored", pll_phase_done, 1);
    hi_delay = 3;

    // Lock lost during WAIT_HI of step 2 of 5
    hi_delay = 20;
    do_req(5, 1'b1, p0, d0);
    k = 0;
    while (!((pulses - p0) == 2 && pll_phase_done === 1'b0) && k < 300) begin
      tick();
      k++;
    end
    chk("unlock_reached_step2", pulses - p0, 2);
    repeat (6) tick();
    pll_locked = 1'b0;
    wait_err(30, lat);
    chk("unlock_err", err, 1);
    chk("unlock_code", err_code, 3);
    chk("unlock_pos", phase_pos, 0);
    chk("unlock_phase_en", pll_phase_en, 0);
    chk("unlock_busy", busy, 0);
    repeat (5) tick();
    chk("unlock_ready", req_ready, 0);
    chk("unlock_pulses", pulses - p0, 2);
    ref_pos   = 0;
    exp_steps = exp_steps + 1;
    exp_errs++;
    pll_locked = 1'b1;
    k = 0;
    while ((req_ready !== 1'b1 || pll_phase_done !== 1'b1) && k < 100) begin
      tick();
      k++;
    end
    chk("relock_ready", req_ready, 1);
    hi_delay = 3;

`ifdef GBT_RX_PHALGNR_DPS_STATS_EN
    chk("stat_steps", stat_steps, exp_steps);
    chk("stat_errs", stat_errs, exp_errs);
`endif

    // Request held during busy, then reset mid-PULSE
    do_req(10, 1'b1, p0, d0);
    req_valid = 1'b1;
    req_steps = 8'd3;
    rdy_hi    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready !== 1'b0) rdy_hi++;
    end
    chk("busy_ready_low", rdy_hi, 0);
    k = 0;
    while (pll_phase_en !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk("mid_pulse_reached", pll_phase_en, 1);
    #2 rst_n = 1'b0;
    #1;
    p_rst = pulses;
    chk("arst_phase_en", pll_phase_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pos", phase_pos, 0);
    chk("arst_err", err, 0);
    chk("arst_done", done, 0);
    chk("arst_updn", pll_updn, 0);
    chk("arst_cntsel", pll_cntsel, 0);
    chk("arst_ready", req_ready, 0);
`ifdef GBT_RX_PHALGNR_DPS_STATS_EN
    chk("arst_stat_steps", stat_steps, 0);
    chk("arst_stat_errs", stat_errs, 0);
`endif
    req_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_pulses", pulses - p_rst, 0);
    chk("post_rst_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
